cell_pos_reader: RTL and testbench

- Read-side sequencer for one per-cell position memory (single-port RAM, 2-cycle read latency, address 0 holds the cell's particle count, addresses 1..N hold {posz, posy, posx}).
- On start, fetches the count, then streams every particle word out over a valid/ready interface with full backpressure support.
- Sits between the cell memory and the force-evaluation / motion-update consumers.
- Absorbs the 2-cycle RAM latency with a small credit-controlled skid FIFO.

---
 rtl/cell_pos_reader.sv | 113 +++++++++++
 tb/tb_cell_pos_reader.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/cell_pos_reader.sv
// cell_pos_reader: streams a cell's particle words from a 2-cycle-latency RAM through a credit-controlled skid FIFO
module cell_pos_reader #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8,
  parameter int PARTICLE_NUM = 220,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rden,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_pid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] IDLE = 2'd0, WAIT_CNT = 2'd1, STREAM = 2'd2, DRAIN = 2'd3;
  localparam logic [ADDR_WIDTH-1:0] MAX_N = ADDR_WIDTH'(PARTICLE_NUM - 1);
  localparam logic [PW+1:0] DEPTH_L = (PW+2)'(FIFO_DEPTH);
  logic [1:0] state;
  logic [ADDR_WIDTH-1:0] next_addr, p0_addr, p1_addr, raw_n, clamp_n;
  logic p0, p1, pop, wr, issue;
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pid [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] cnt;
  logic [PW+1:0] occ;
  always_comb begin
    out_valid = cnt != '0;
    out_data = out_valid ? fifo_data[rd_ptr] : '0;
    out_pid = out_valid ? fifo_pid[rd_ptr] : '0;
    out_last = out_valid && out_pid == particle_count;
    pop = out_valid && out_ready;
    wr = p1 && (state == STREAM || state == DRAIN);
    // occupancy after this edge if one more read is issued: FIFO plus every read still in the RAM pipe
    occ = (PW+2)'(cnt) + (PW+2)'(p1) + (PW+2)'(p0) + (PW+2)'(mem_rden) + (PW+2)'(1) - (PW+2)'(pop);
    issue = state == STREAM && occ <= DEPTH_L;
    raw_n = mem_q[ADDR_WIDTH-1:0];
    clamp_n = raw_n > MAX_N ? MAX_N : raw_n;
  end
  always_ff @(posedge clk)
    if (wr) begin
      fifo_data[wr_ptr] <= mem_q;
      fifo_pid[wr_ptr] <= p1_addr;
    end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      mem_rden <= 1'b0;
      mem_addr <= '0;
      particle_count <= '0;
      next_addr <= '0;
      p0 <= 1'b0;
      p1 <= 1'b0;
      p0_addr <= '0;
      p1_addr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      done <= 1'b0;
      mem_rden <= issue;
      p0 <= mem_rden;
      p1 <= p0;
      p0_addr <= mem_addr;
      p1_addr <= p0_addr;
      if (issue) begin
        mem_addr <= next_addr;
        next_addr <= next_addr + 1'b1;
      end
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (PW+1)'(wr) - (PW+1)'(pop);
      case (state)
        IDLE:
          if (start) begin
            mem_rden <= 1'b1;
            mem_addr <= '0;
            busy <= 1'b1;
            state <= WAIT_CNT;
          end
        WAIT_CNT:
          if (p1) begin
            particle_count <= clamp_n;
            if (clamp_n == '0) begin
              done <= 1'b1;
              busy <= 1'b0;
              state <= IDLE;
            end else begin
              next_addr <= ADDR_WIDTH'(1);
              state <= STREAM;
            end
          end
        STREAM:
          if (issue && next_addr == particle_count) state <= DRAIN;
        default:
          if (pop && out_last) begin
            done <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end
      endcase
    end
endmodule

// File: tb/tb_cell_pos_reader.sv
// tb_cell_pos_reader: directed tests with a queue-level reference of the expected particle stream
module tb_cell_pos_reader;
  localparam int DW = 96, AW = 8, PN = 220;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b1;
  logic busy, done, mem_rden, out_valid, out_last;
  logic [AW-1:0] particle_count, mem_addr, out_pid;
  logic [DW-1:0] mem_q = '0, q1 = '0, out_data;
  logic [DW-1:0] mem [256];
  int checks = 0, passes = 0;
  bit mon_on = 0, last_hs = 0, stall = 0;
  int exp_n = 0, idx = 1, issued = 0, accepted = 0, rmode = 0, rcyc = 0;
  int rd_log[$];
  logic [DW-1:0] held_d;
  logic [AW-1:0] held_p;

  always #5 clk = ~clk;

  cell_pos_reader dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .particle_count(particle_count), .mem_addr(mem_addr), .mem_rden(mem_rden),
    .mem_q(mem_q), .out_data(out_data), .out_pid(out_pid), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  always @(posedge clk) begin
    q1 <= mem_rden ? mem[mem_addr] : '0;
    mem_q <= q1;
  end

  always @(posedge clk) begin
    #1;
    rcyc = rcyc + 1;
    case (rmode)
      1: out_ready = (rcyc % 4 == 0) || (rcyc % 4 == 3);
      2: out_ready = rcyc > 28;
      default: out_ready = 1'b1;
    endcase
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk)
    if (mon_on) begin
      if (mem_rden) begin
        rd_log.push_back(int'(mem_addr));
        if (mem_addr != 0) issued++;
      end
      chk("occupancy_le_4", 128'(issued - accepted <= 4), 128'(1));
      if (stall) begin
        chk("stall_valid", 128'(out_valid), 128'(1));
        chk("stall_data", 128'(out_data), 128'(held_d));
        chk("stall_pid", 128'(out_pid), 128'(held_p));
      end
      if (out_valid) begin
        chk("pid", 128'(out_pid), 128'(idx));
        chk("data", 128'(out_data), 128'(mem[idx[7:0]]));
        chk("last", 128'(out_last), 128'(idx == exp_n));
      end
      if (exp_n > 0) chk("done_timing", 128'(done), 128'(last_hs));
      last_hs = out_valid && out_ready && idx == exp_n;
      stall = out_valid && !out_ready;
      held_d = out_data;
      held_p = out_pid;
      if (out_valid && out_ready) begin
        idx++;
        accepted++;
      end
    end

  task automatic run_cell(input int field, input int mode, input int restart_k, input int pin_done, input int pin_valid);
    int n, k, first_v, bad;
    bit got;
    n = field > PN - 1 ? PN - 1 : field;
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom};
    mem[0][7:0] = field[7:0];
    exp_n = n; idx = 1; last_hs = 0; stall = 0; issued = 0; accepted = 0;
    rd_log.delete();
    rmode = mode;
    @(negedge clk);
    rcyc = 0;
    mon_on = 1;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    got = 0; first_v = 0; k = 0;
    while (!got && k < 3000) begin
      k++;
      @(negedge clk);
      if (k == 1) chk("busy_after_start", 128'(busy), 128'(1));
      if (k == restart_k) start = 1'b1;
      if (k == restart_k + 1) start = 1'b0;
      if (out_valid && first_v == 0) first_v = k;
      if (done) got = 1;
    end
    start = 1'b0;
    chk("done_seen", 128'(got), 128'(1));
    if (pin_done > 0) chk("done_cycle", 128'(k), 128'(pin_done));
    if (pin_valid > 0) chk("first_valid_cycle", 128'(first_v), 128'(pin_valid));
    if (n == 0) chk("no_valid_zero", 128'(first_v), 128'(0));
    chk("busy_at_done", 128'(busy), 128'(0));
    chk("particle_count", 128'(particle_count), 128'(n));
    @(negedge clk);
    chk("done_single_pulse", 128'(done), 128'(0));
    mon_on = 0;
    chk("all_delivered", 128'(idx), 128'(n + 1));
    chk("read_count", 128'(rd_log.size()), 128'(n + 1));
    bad = 0;
    foreach (rd_log[i]) if (rd_log[i] != i) bad++;
    chk("read_order", 128'(bad), 128'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
    chk({tag, "_rden"}, 128'(mem_rden), 128'(0));
    chk({tag, "_addr"}, 128'(mem_addr), 128'(0));
    chk({tag, "_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_last"}, 128'(out_last), 128'(0));
    chk({tag, "_data"}, 128'(out_data), 128'(0));
    chk({tag, "_pid"}, 128'(out_pid), 128'(0));
    chk({tag, "_count"}, 128'(particle_count), 128'(0));
  endtask

  initial begin
    int any_done;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #2 rst = 1'b0;
    run_cell(3, 0, -1, 11, 8);
    run_cell(0, 0, -1, 4, -1);
    run_cell(10, 1, -1, -1, 8);
    run_cell(250, 0, -1, -1, 8);
    run_cell(5, 0, 6, -1, 8);
    // abort a stream with reset in the middle of delivery
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom};
    mem[0][7:0] = 8'd10;
    rmode = 0;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    any_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || out_valid || mem_rden) any_done++;
    end
    chk("midrst_quiet", 128'(any_done), 128'(0));
    run_cell(3, 0, -1, 11, 8);
    run_cell(1, 2, -1, 29, 8);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
